// File: rtl/serial_adder_n.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first,
// framed by a start/busy/done handshake.
module serial_adder_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;

  // Single full-adder cell working on the current LSBs and the carry flop
  assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_c        = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
  assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

  // Control FSM and datapath; operands are captured only on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sum_sh <= w_sum_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_c;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            // r_carry here is the carry into the MSB, w_c the carry out of it
            r_sum      <= w_sum_next;
            r_cout     <= w_c;
            r_overflow <= r_carry ^ w_c;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n at WIDTH=8 (directed) and WIDTH=2 (exhaustive).
module tb_serial_adder_n;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp8_t;

  typedef struct packed {
    logic [1:0] s;
    logic       c;
    logic       o;
  } exp2_t;

  logic       clk;
  logic       reset;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;

  exp8_t q8[$];
  exp2_t q2[$];

  int n_checks;
  int n_pass;
  int cyc;
  int start_edge;
  int done_cnt8;
  int done_cyc_last8;
  int done_cyc_prev8;
  logic prev_done8;
  logic prev_done2;

  serial_adder_n #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_n #(.WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor for the 8-bit instance: pop and compare on every done pulse
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      exp8_t e;
      chk("done8_single_cycle", 32'(prev_done8), 32'd0);
      done_cnt8++;
      done_cyc_prev8 = done_cyc_last8;
      done_cyc_last8 = cyc;
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.s));
        chk("cout8", 32'(cout8), 32'(e.c));
        chk("ovf8", 32'(ovf8), 32'(e.o));
      end
    end
    prev_done8 = done8;
  end

  // Monitor for the 2-bit instance
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      exp2_t e;
      if (q2.size() == 0) begin
        chk("done2_unexpected", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("sum2", 32'(sum2), 32'(e.s));
        chk("cout2", 32'(cout2), 32'(e.c));
        chk("ovf2", 32'(ovf2), 32'(e.o));
      end
    end
    prev_done2 = done2;
  end

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [7:0] es, input logic ec, input logic eo, input bit push);
    exp8_t e;
    @(posedge clk); #1;
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    start_edge = cyc + 1;
    e.s = es; e.c = ec; e.o = eo;
    if (push) q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_q8();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (q8.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("done8_timeout", 32'd1, 32'd0);
      q8.delete();
    end
  endtask

  task automatic wait_q2();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (q2.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("done2_timeout", 32'd1, 32'd0);
      q2.delete();
    end
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     input logic [7:0] es, input logic ec, input logic eo);
    issue8(ia, ib, ic, es, ec, eo, 1'b1);
    wait_q8();
  endtask

  initial begin
    int d0;
    n_checks = 0; n_pass = 0; cyc = 0; start_edge = 0;
    done_cnt8 = 0; done_cyc_last8 = 0; done_cyc_prev8 = 0;
    prev_done8 = 1'b0; prev_done2 = 1'b0;
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    reset = 1'b0;

    // 1: zero add and latency
    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("latency", 32'(done_cyc_last8 - start_edge), 32'd8);

    // 2: unsigned carry and signed overflow
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // 3: start pulsed mid-SHIFT is ignored
    d0 = done_cnt8;
    issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_q8();
    repeat (12) @(posedge clk);
    #1;
    chk("ignored_start_done_count", 32'(done_cnt8 - d0), 32'd1);

    // 4: reset three edges into SHIFT aborts the operation
    d0 = done_cnt8;
    issue8(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("shift_busy", 32'(busy8), 32'd1);
    chk("shift_sum_stable", 32'(sum8), 32'hFF);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(cout8), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt8 - d0), 32'd0);
    op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // 5: back-to-back with start held across DONE
    d0 = done_cnt8;
    begin
      exp8_t e1, e2;
      e1.s = 8'h00; e1.c = 1'b1; e1.o = 1'b1;
      e2.s = 8'h03; e2.c = 1'b0; e2.o = 1'b0;
      @(posedge clk); #1;
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      q8.push_back(e1);
      q8.push_back(e2);
      @(posedge clk); #1;
      a8 = 8'h01; b8 = 8'h02;
      repeat (9) @(posedge clk);
      #1;
      start8 = 1'b0;
    end
    wait_q8();
    chk("b2b_done_count", 32'(done_cnt8 - d0), 32'd2);
    chk("b2b_gap", 32'(done_cyc_last8 - done_cyc_prev8), 32'd9);

    // 6: WIDTH=2 exhaustive against a+b+cin
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      logic [2:0] t;
      int sa, sb, ss;
      exp2_t e;
      v = 5'(i);
      t = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
      sa = v[4] ? int'(v[4:3]) - 4 : int'(v[4:3]);
      sb = v[2] ? int'(v[2:1]) - 4 : int'(v[2:1]);
      ss = sa + sb + int'(v[0]);
      e.s = t[1:0];
      e.c = t[2];
      e.o = (ss > 1 || ss < -2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0]; start2 = 1'b1;
      q2.push_back(e);
      @(posedge clk); #1;
      start2 = 1'b0;
      wait_q2();
    end

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
